// File: rtl/int_request_gen.sv
// rtl/int_request_gen.sv - NMI/IRQ request generator with enable masks and status registers
// NMI side emits fixed-width low pulses separated by a guaranteed high gap; IRQ side is level-sensitive.
module int_request_gen #(
  parameter int NMI_PULSE = 2,
  parameter int NMI_GAP   = 2
) (
  input  logic       phi2,
  input  logic       rstAll_L,
  input  logic [1:0] addr,
  input  logic [7:0] dataIn,
  input  logic       we,
  output logic [7:0] dataOut,
  input  logic [2:0] nmiEvt,
  input  logic [7:0] irqEvt,
  output logic       NMI_L,
  output logic       IRQ_L
);

  localparam int CNT_MAX = ((NMI_PULSE > NMI_GAP) ? NMI_PULSE : NMI_GAP) - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(NMI_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(NMI_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } nmi_state_e;

  nmi_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             nmiPend_q;
  logic             nmi_l_q;
  logic             irq_l_q;

  logic [2:0] nmiEn_q, nmiEn_d;
  logic [2:0] nmiSt_q, nmiSt_d;
  logic [7:0] irqEn_q, irqEn_d;
  logic [7:0] irqSt_q, irqSt_d;
  logic       nmi_req;

  // Request uses the enable held before this edge; status sets regardless of enable.
  assign nmi_req = |(nmiEvt & nmiEn_q);

  always_comb begin
    nmiEn_d = nmiEn_q;
    nmiSt_d = nmiSt_q;
    irqEn_d = irqEn_q;
    if (we && addr == 2'd0) nmiEn_d = dataIn[7:5];
    if (we && addr == 2'd1) nmiSt_d = 3'b000;
    if (we && addr == 2'd2) irqEn_d = dataIn;
    nmiSt_d = nmiSt_d | nmiEvt;
    irqSt_d = (irqSt_q | irqEvt) & irqEn_d;
  end

  always_comb begin
    dataOut = 8'hFF;
    case (addr)
      2'd1:    dataOut = {nmiSt_q, 5'b00000};
      2'd3:    dataOut = irqSt_q;
      default: dataOut = 8'hFF;
    endcase
  end

  always_ff @(posedge phi2 or negedge rstAll_L) begin
    if (!rstAll_L) begin
      nmiEn_q <= 3'b000;
      nmiSt_q <= 3'b000;
      irqEn_q <= 8'h00;
      irqSt_q <= 8'h00;
      irq_l_q <= 1'b1;
    end else begin
      nmiEn_q <= nmiEn_d;
      nmiSt_q <= nmiSt_d;
      irqEn_q <= irqEn_d;
      irqSt_q <= irqSt_d;
      irq_l_q <= ~|(irqSt_d & irqEn_d);
    end
  end

  always_ff @(posedge phi2 or negedge rstAll_L) begin
    if (!rstAll_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      nmiPend_q <= 1'b0;
      nmi_l_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (nmi_req || nmiPend_q) begin
            state_q   <= S_PULSE;
            nmi_l_q   <= 1'b0;
            cnt_q     <= PULSE_LOAD;
            nmiPend_q <= 1'b0;
          end
        end
        S_PULSE: begin
          if (nmi_req) nmiPend_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= S_GAP;
            nmi_l_q <= 1'b1;
            cnt_q   <= GAP_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            // Everything queued during pulse and gap collapses into this one pulse.
            if (nmiPend_q || nmi_req) begin
              state_q   <= S_PULSE;
              nmi_l_q   <= 1'b0;
              cnt_q     <= PULSE_LOAD;
              nmiPend_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            if (nmi_req) nmiPend_q <= 1'b1;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign NMI_L = nmi_l_q;
  assign IRQ_L = irq_l_q;

endmodule

// File: tb/tb_int_request_gen.sv
// tb/tb_int_request_gen.sv - directed self-checking bench for int_request_gen
module tb_int_request_gen;

  logic       phi2 = 1'b0;
  logic       rstAll_L;
  logic [1:0] addr;
  logic [7:0] dataIn;
  logic       we;
  logic [7:0] dataOut;
  logic [2:0] nmiEvt;
  logic [7:0] irqEvt;
  logic       NMI_L;
  logic       IRQ_L;

  int n_checks = 0;
  int n_fail   = 0;

  int_request_gen #(.NMI_PULSE(2), .NMI_GAP(2)) dut (
    .phi2(phi2), .rstAll_L(rstAll_L), .addr(addr), .dataIn(dataIn), .we(we),
    .dataOut(dataOut), .nmiEvt(nmiEvt), .irqEvt(irqEvt), .NMI_L(NMI_L), .IRQ_L(IRQ_L)
  );

  always #5 phi2 = ~phi2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge phi2);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    addr = a; dataIn = d; we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic test_reset;
    rstAll_L = 1'b0; addr = 2'd0; dataIn = 8'h00; we = 1'b0; nmiEvt = 3'b000; irqEvt = 8'h00;
    tick(3);
    rstAll_L = 1'b1;
    tick(1);
    addr = 2'd1; #1;
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_nmist: got %h expected 00", dataOut); end
    addr = 2'd3; #1;
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_irqst: got %h expected 00", dataOut); end
    n_checks++; if (NMI_L !== 1'b1) begin n_fail++; $display("FAIL reset_nmi_l: got %b expected 1", NMI_L); end
    n_checks++; if (IRQ_L !== 1'b1) begin n_fail++; $display("FAIL reset_irq_l: got %b expected 1", IRQ_L); end
    addr = 2'd0; #1;
    n_checks++; if (dataOut !== 8'hFF) begin n_fail++; $display("FAIL read_addr0: got %h expected FF", dataOut); end
    addr = 2'd2; #1;
    n_checks++; if (dataOut !== 8'hFF) begin n_fail++; $display("FAIL read_addr2: got %h expected FF", dataOut); end
  endtask

  task automatic test_nmi_single;
    logic [3:0] exp_l;
    exp_l = 4'b1100;
    write_reg(2'd0, 8'h40);
    nmiEvt = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      nmiEvt = 3'b000;
      n_checks++; if (NMI_L !== exp_l[i]) begin n_fail++; $display("FAIL nmi_single_c%0d: got %b expected %b", i, NMI_L, exp_l[i]); end
    end
    addr = 2'd1; #1;
    n_checks++; if (dataOut !== 8'h40) begin n_fail++; $display("FAIL nmist_vbi: got %h expected 40", dataOut); end
    write_reg(2'd1, 8'hFF);
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL nmires: got %h expected 00", dataOut); end
    tick(2);
  endtask

  task automatic test_nmi_masked_and_queue;
    logic [7:0] exp_l;
    exp_l = 8'b11001100;
    write_reg(2'd0, 8'h00);
    nmiEvt = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      nmiEvt = 3'b000;
      n_checks++; if (NMI_L !== 1'b1) begin n_fail++; $display("FAIL nmi_masked_c%0d: got %b expected 1", i, NMI_L); end
    end
    addr = 2'd1; #1;
    n_checks++; if (dataOut !== 8'h80) begin n_fail++; $display("FAIL nmist_masked_dli: got %h expected 80", dataOut); end
    write_reg(2'd1, 8'h00);
    write_reg(2'd0, 8'hC0);
    for (int i = 0; i < 8; i++) begin
      nmiEvt = (i == 0) ? 3'b100 : (i == 1) ? 3'b010 : 3'b000;
      tick(1);
      n_checks++; if (NMI_L !== exp_l[i]) begin n_fail++; $display("FAIL nmi_queue_c%0d: got %b expected %b", i, NMI_L, exp_l[i]); end
    end
    nmiEvt = 3'b000;
    tick(4);
  endtask

  task automatic test_nmi_merge;
    logic [5:0] exp_l;
    exp_l = 6'b111100;
    write_reg(2'd1, 8'h00);
    write_reg(2'd0, 8'hE0);
    nmiEvt = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      nmiEvt = 3'b000;
      n_checks++; if (NMI_L !== exp_l[i]) begin n_fail++; $display("FAIL nmi_merge_c%0d: got %b expected %b", i, NMI_L, exp_l[i]); end
    end
    addr = 2'd1; #1;
    n_checks++; if (dataOut !== 8'hE0) begin n_fail++; $display("FAIL nmist_all: got %h expected E0", dataOut); end
    nmiEvt = 3'b010;
    write_reg(2'd1, 8'h00);
    nmiEvt = 3'b000;
    n_checks++; if (dataOut !== 8'h40) begin n_fail++; $display("FAIL nmires_vs_event: got %h expected 40", dataOut); end
    tick(6);
  endtask

  task automatic test_irq;
    write_reg(2'd2, 8'h05);
    n_checks++; if (IRQ_L !== 1'b1) begin n_fail++; $display("FAIL irq_idle: got %b expected 1", IRQ_L); end
    irqEvt = 8'h07;
    tick(1);
    irqEvt = 8'h00;
    addr = 2'd3; #1;
    n_checks++; if (dataOut !== 8'h05) begin n_fail++; $display("FAIL irqst_set: got %h expected 05", dataOut); end
    n_checks++; if (IRQ_L !== 1'b0) begin n_fail++; $display("FAIL irq_assert: got %b expected 0", IRQ_L); end
    write_reg(2'd2, 8'h04);
    addr = 2'd3; #1;
    n_checks++; if (dataOut !== 8'h04) begin n_fail++; $display("FAIL irqst_partial_clear: got %h expected 04", dataOut); end
    n_checks++; if (IRQ_L !== 1'b0) begin n_fail++; $display("FAIL irq_still_low: got %b expected 0", IRQ_L); end
    write_reg(2'd2, 8'h00);
    addr = 2'd3; #1;
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL irqst_clear: got %h expected 00", dataOut); end
    n_checks++; if (IRQ_L !== 1'b1) begin n_fail++; $display("FAIL irq_deassert: got %b expected 1", IRQ_L); end
    irqEvt = 8'h81;
    write_reg(2'd2, 8'h80);
    irqEvt = 8'h00;
    addr = 2'd3; #1;
    n_checks++; if (dataOut !== 8'h80) begin n_fail++; $display("FAIL irqst_same_cycle_en: got %h expected 80", dataOut); end
    n_checks++; if (IRQ_L !== 1'b0) begin n_fail++; $display("FAIL irq_same_cycle_en: got %b expected 0", IRQ_L); end
    write_reg(2'd2, 8'h00);
  endtask

  task automatic test_reset_mid_pulse;
    write_reg(2'd0, 8'hE0);
    nmiEvt = 3'b001;
    tick(1);
    tick(1);
    nmiEvt = 3'b000;
    n_checks++; if (NMI_L !== 1'b0) begin n_fail++; $display("FAIL pre_reset_pulse: got %b expected 0", NMI_L); end
    #2;
    rstAll_L = 1'b0;
    #1;
    n_checks++; if (NMI_L !== 1'b1) begin n_fail++; $display("FAIL async_reset_nmi_l: got %b expected 1", NMI_L); end
    addr = 2'd1; #1;
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL async_reset_nmist: got %h expected 00", dataOut); end
    tick(1);
    rstAll_L = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      n_checks++; if (NMI_L !== 1'b1) begin n_fail++; $display("FAIL post_reset_quiet_c%0d: got %b expected 1", i, NMI_L); end
    end
  endtask

  initial begin
    test_reset();
    test_nmi_single();
    test_nmi_masked_and_queue();
    test_nmi_merge();
    test_irq();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
